// File: rtl/legv8_mem_arb_pkg.sv
// Shared definitions for the LEGv8 instruction/data memory arbiter:
// FSM state encoding, transaction owner encoding, statistics counter width
// and the fixed-priority-with-fairness arbitration rule.
package legv8_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   localparam int STAT_W = 16;

   // Data normally wins; a pending fetch wins once the data streak hits its limit.
   function automatic logic dm_wins(input logic if_req, input logic dm_req, input logic at_limit);
      return dm_req && !(if_req && at_limit);
   endfunction

endpackage

// File: rtl/legv8_mem_arb_stats.sv
// Grant and conflict counters for the LEGv8 memory arbiter.
// Each counter is STAT_W bits wide, wraps naturally and clears on reset.
module legv8_mem_arb_stats
   import legv8_mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              if_grant,
   input  logic              dm_grant,
   input  logic              conflict,
   output logic [STAT_W-1:0] stat_if_grants,
   output logic [STAT_W-1:0] stat_dm_grants,
   output logic [STAT_W-1:0] stat_conflicts
);

   // Count each grant pulse and each IDLE cycle that saw both requesters.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_if_grants <= '0;
         stat_dm_grants <= '0;
         stat_conflicts <= '0;
      end else begin
         if (if_grant) stat_if_grants <= stat_if_grants + STAT_W'(1);
         if (dm_grant) stat_dm_grants <= stat_dm_grants + STAT_W'(1);
         if (conflict) stat_conflicts <= stat_conflicts + STAT_W'(1);
      end
   end

endmodule

// File: rtl/legv8_mem_arbiter.sv
// Single-port memory arbiter shared by the LEGv8 fetch and load/store paths.
// One transaction is in flight at a time: IDLE latches the winner, ISSUE
// strobes the memory, WAIT counts out the read latency, RESP pulses the ack.
// Optional macro LEGV8_MEM_ARB_STATS_EN adds 16-bit grant/conflict counters.
module legv8_mem_arbiter
   import legv8_mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter int MEM_LAT      = 1,
   parameter int DM_BURST_MAX = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
`ifdef LEGV8_MEM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_if_grants,
   output logic [STAT_W-1:0] stat_dm_grants,
   output logic [STAT_W-1:0] stat_conflicts
`endif
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam int SK_W  = $clog2(DM_BURST_MAX + 1);

   state_t           state;
   owner_t           owner;
   logic [CNT_W-1:0] wait_cnt;
   logic [SK_W-1:0]  streak;
   logic             in_idle;
   logic             at_limit;
   logic             dm_grant;
   logic             if_grant;

   assign in_idle  = (state == IDLE);
   assign at_limit = (streak == SK_W'(DM_BURST_MAX));
   assign dm_grant = in_idle && dm_wins(if_req, dm_req, at_limit);
   assign if_grant = in_idle && if_req && !dm_grant;
   assign busy     = !in_idle;

   // Transaction FSM; the latched memory port registers double as the owner's request copy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= OWN_IF;
         wait_cnt  <= '0;
         streak    <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         dm_ack    <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         if_ack <= 1'b0;
         dm_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (dm_grant) begin
                  owner     <= OWN_DM;
                  mem_en    <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  if (if_req && !at_limit) streak <= streak + SK_W'(1);
                  state     <= ISSUE;
               end else if (if_grant) begin
                  owner    <= OWN_IF;
                  mem_en   <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= if_addr;
                  streak   <= '0;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               if (mem_we) begin
                  if (owner == OWN_DM) dm_ack <= 1'b1;
                  else                 if_ack <= 1'b1;
                  state <= RESP;
               end else begin
                  wait_cnt <= CNT_W'(MEM_LAT);
                  state    <= WAIT;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - CNT_W'(1);
               if (wait_cnt == CNT_W'(1)) begin
                  if (owner == OWN_DM) begin
                     dm_rdata <= mem_rdata;
                     dm_ack   <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_ack   <= 1'b1;
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef LEGV8_MEM_ARB_STATS_EN
   logic conflict;

   assign conflict = in_idle && if_req && dm_req;

   legv8_mem_arb_stats u_stats (
      .clk            (clk),
      .reset          (reset),
      .if_grant       (if_grant),
      .dm_grant       (dm_grant),
      .conflict       (conflict),
      .stat_if_grants (stat_if_grants),
      .stat_dm_grants (stat_dm_grants),
      .stat_conflicts (stat_conflicts)
   );
`endif

endmodule
